// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      StHold     = 3'd0,
      StWaitLock = 3'd1,
      StStable   = 3'd2,
      StRun      = 3'd3,
      StFail     = 3'd4
   } pll_state_e;

   function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the raw PLL lock indication into the refclk domain.
module pll_lock_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out
);

   logic meta_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q   <= 1'b0;
         sync_out <= 1'b0;
      end else begin
         meta_q   <= async_in;
         sync_out <= meta_q;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the PLL in reset, waits for and qualifies lock, then releases core reset;
// re-sequences on lock loss or restart and gives up after repeated lock timeouts.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 74250,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 7,
   parameter int unsigned CNT_W         = 8
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               restart,
   output logic               pll_rst,
   output logic               core_rst,
   output logic               pll_ready,
   output logic               fail,
   output logic [STATE_W-1:0] state,
   output logic [3:0]         retry_count,
   output logic [CNT_W-1:0]   loss_count
);

   localparam int unsigned TMAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int unsigned TW   = $clog2(TMAX + 1);

   logic             lk;
   pll_state_e       state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [3:0]       retry_q, retry_d;
   logic [CNT_W-1:0] loss_q, loss_d;
   logic             pll_rst_d, core_rst_d, pll_ready_d, fail_d;

   pll_lock_sync u_lock_sync (
      .clk      (refclk),
      .rst      (rst),
      .async_in (pll_locked),
      .sync_out (lk)
   );

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q   <= StHold;
         timer_q   <= '0;
         retry_q   <= '0;
         loss_q    <= '0;
         pll_rst   <= 1'b1;
         core_rst  <= 1'b1;
         pll_ready <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         retry_q   <= retry_d;
         loss_q    <= loss_d;
         pll_rst   <= pll_rst_d;
         core_rst  <= core_rst_d;
         pll_ready <= pll_ready_d;
         fail      <= fail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      retry_d = retry_q;
      loss_d  = loss_q;
      case (state_q)
         StHold: begin
            if (timer_q == TW'(RST_CYCLES - 1)) begin
               state_d = StWaitLock;
               timer_d = '0;
            end
         end
         StWaitLock: begin
            if (lk) begin
               state_d = StStable;
               timer_d = '0;
            end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
               retry_d = retry_q + 4'd1;
               state_d = (retry_d == 4'(MAX_RETRIES)) ? StFail : StHold;
               timer_d = '0;
            end
         end
         StStable: begin
            if (!lk) begin
               state_d = StWaitLock;
               timer_d = '0;
            end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
               state_d = StRun;
               timer_d = '0;
               retry_d = '0;
            end
         end
         StRun: begin
            timer_d = '0;
            if (!lk) begin
               state_d = StHold;
               if (loss_q != '1) loss_d = loss_q + 1'b1;
            end
         end
         StFail: timer_d = '0;
         default: begin
            state_d = StHold;
            timer_d = '0;
         end
      endcase
      // Restart overrides every transition except the loss count in RUN.
      if (restart) begin
         state_d = StHold;
         timer_d = '0;
         retry_d = '0;
      end
   end

   // Decode from next state so the outputs are registered alongside state_q.
   always_comb begin
      pll_rst_d   = 1'b1;
      core_rst_d  = 1'b1;
      pll_ready_d = 1'b0;
      fail_d      = 1'b0;
      case (state_d)
         StWaitLock, StStable: pll_rst_d = 1'b0;
         StRun: begin
            pll_rst_d   = 1'b0;
            core_rst_d  = 1'b0;
            pll_ready_d = 1'b1;
         end
         StFail:  fail_d = 1'b1;
         default: ;
      endcase
   end

   assign state       = state_q;
   assign retry_count = retry_q;
   assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;

   logic       refclk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       restart;
   logic       pll_rst, core_rst, pll_ready, fail;
   logic [2:0] state;
   logic [3:0] retry_count;
   logic [1:0] loss_count;

   int total = 0;
   int bad   = 0;

   pll_lock_sequencer #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8),
      .MAX_RETRIES   (2),
      .CNT_W         (2)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .restart     (restart),
      .pll_rst     (pll_rst),
      .core_rst    (core_rst),
      .pll_ready   (pll_ready),
      .fail        (fail),
      .state       (state),
      .retry_count (retry_count),
      .loss_count  (loss_count)
   );

   always #5 refclk = ~refclk;

   task automatic tick(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // From HOLD entry (timer 0, synchronizer low): lock raised now reaches RUN 13 edges later.
   task automatic relock(input string tag);
      pll_locked = 1'b1;
      tick(4);
      check({tag, "_wait"}, 32'(state), 1);
      tick(1);
      check({tag, "_stable"}, 32'(state), 2);
      tick(8);
      check({tag, "_run"}, 32'(state), 3);
      check({tag, "_core_rst"}, 32'(core_rst), 0);
      check({tag, "_ready"}, 32'(pll_ready), 1);
   endtask

   task automatic drop_in_run(input string tag, input int exp_loss);
      pll_locked = 1'b0;
      tick(2);
      check({tag, "_still_run"}, 32'(core_rst), 0);
      tick(1);
      check({tag, "_core_rst"}, 32'(core_rst), 1);
      check({tag, "_state"}, 32'(state), 0);
      check({tag, "_loss"}, 32'(loss_count), 32'(exp_loss));
   endtask

   initial begin
      rst        = 1'b1;
      pll_locked = 1'b0;
      restart    = 1'b0;
      tick(2);
      check("rst_state", 32'(state), 0);
      check("rst_pll_rst", 32'(pll_rst), 1);
      check("rst_core_rst", 32'(core_rst), 1);
      check("rst_ready", 32'(pll_ready), 0);
      check("rst_fail", 32'(fail), 0);
      check("rst_retry", 32'(retry_count), 0);
      check("rst_loss", 32'(loss_count), 0);

      // Clean start
      rst = 1'b0;
      tick(3);
      check("cs_hold", 32'(state), 0);
      check("cs_hold_pll_rst", 32'(pll_rst), 1);
      tick(1);
      check("cs_wait", 32'(state), 1);
      check("cs_pll_rst_low", 32'(pll_rst), 0);
      check("cs_core_rst", 32'(core_rst), 1);
      tick(1);
      pll_locked = 1'b1;
      tick(2);
      check("cs_sync_delay", 32'(state), 1);
      tick(1);
      check("cs_stable", 32'(state), 2);
      tick(7);
      check("cs_stable_end", 32'(state), 2);
      check("cs_core_rst_held", 32'(core_rst), 1);
      tick(1);
      check("cs_run", 32'(state), 3);
      check("cs_core_rst_rel", 32'(core_rst), 0);
      check("cs_ready", 32'(pll_ready), 1);
      check("cs_retry", 32'(retry_count), 0);

      // Lock loss, saturating counter
      drop_in_run("loss1", 1);
      relock("rl1");
      drop_in_run("loss2", 2);
      relock("rl2");
      drop_in_run("loss3", 3);
      relock("rl3");
      drop_in_run("loss4", 3);
      relock("rl4");

      // Glitchy lock in STABLE
      pll_locked = 1'b0;
      tick(3);
      check("gl_hold", 32'(state), 0);
      tick(4);
      check("gl_wait", 32'(state), 1);
      pll_locked = 1'b1;
      tick(3);
      check("gl_stable", 32'(state), 2);
      pll_locked = 1'b0;
      tick(3);
      check("gl_back_wait", 32'(state), 1);
      check("gl_retry", 32'(retry_count), 0);
      pll_locked = 1'b1;
      tick(3);
      check("gl_stable2", 32'(state), 2);
      tick(7);
      check("gl_not_yet", 32'(state), 2);
      tick(1);
      check("gl_run", 32'(state), 3);

      // Timeouts to FAIL, then restart
      pll_locked = 1'b0;
      tick(3);
      check("to_hold", 32'(state), 0);
      tick(4);
      check("to_wait", 32'(state), 1);
      tick(19);
      check("to_pre1", 32'(state), 1);
      check("to_pre1_retry", 32'(retry_count), 0);
      tick(1);
      check("to_hold1", 32'(state), 0);
      check("to_retry1", 32'(retry_count), 1);
      check("to_pll_rst1", 32'(pll_rst), 1);
      tick(4);
      check("to_wait2", 32'(state), 1);
      tick(19);
      check("to_pre2", 32'(state), 1);
      tick(1);
      check("to_fail", 32'(state), 4);
      check("to_fail_flag", 32'(fail), 1);
      check("to_fail_pll_rst", 32'(pll_rst), 1);
      check("to_fail_core_rst", 32'(core_rst), 1);
      check("to_fail_retry", 32'(retry_count), 2);
      tick(5);
      check("to_fail_sticky", 32'(state), 4);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      check("rs_state", 32'(state), 0);
      check("rs_fail", 32'(fail), 0);
      check("rs_retry", 32'(retry_count), 0);

      // Async reset mid-STABLE
      pll_locked = 1'b1;
      tick(4);
      check("ar_wait", 32'(state), 1);
      tick(1);
      check("ar_stable", 32'(state), 2);
      tick(3);
      #2 rst = 1'b1;
      #1;
      check("ar_state", 32'(state), 0);
      check("ar_pll_rst", 32'(pll_rst), 1);
      check("ar_core_rst", 32'(core_rst), 1);
      check("ar_loss", 32'(loss_count), 0);
      @(negedge refclk);
      rst = 1'b0;
      relock("ar_rl");

      // Restart together with a lock drop in RUN
      pll_locked = 1'b0;
      tick(2);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      check("sr_state", 32'(state), 0);
      check("sr_loss", 32'(loss_count), 1);
      check("sr_core_rst", 32'(core_rst), 1);
      relock("sr_rl");

      // Restart on the final timeout cycle
      pll_locked = 1'b0;
      tick(3);
      check("st_hold", 32'(state), 0);
      check("st_loss", 32'(loss_count), 2);
      tick(4);
      tick(19);
      tick(1);
      check("st_retry1", 32'(retry_count), 1);
      tick(4);
      check("st_wait2", 32'(state), 1);
      tick(19);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      check("st_state", 32'(state), 0);
      check("st_fail", 32'(fail), 0);
      check("st_retry0", 32'(retry_count), 0);
      tick(1);
      check("st_still_hold", 32'(state), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
